mem_read_arbiter: RTL and testbench

//  Shares one sys_mem read port among N client requesters (fetch, load, debug).

---
 rtl/sys.sv | 15 +
 rtl/mem_read_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_read_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sys.sv
// Shared system types for the sys_mem read port.
package sys;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [3:0]  size;
  } mem_read_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        done;
  } mem_read_rsp_t;

endpackage

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing the sys_mem read port among n_clients requesters.
// Each access runs IDLE -> ISSUE -> CAPTURE; malformed or out-of-range
// requests go IDLE -> ERROR and never reach memory.
module mem_read_arbiter #(
  parameter int unsigned n_clients  = 4,
  parameter int unsigned addr_width = 32,
  parameter int unsigned word_bytes = 4,
  parameter int unsigned mem_size   = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [n_clients-1:0]             cli_req_valid,
  output logic [n_clients-1:0]             cli_req_ready,
  input  logic [n_clients*addr_width-1:0]  cli_req_addr,
  input  logic [n_clients*4-1:0]           cli_req_size,
  output logic [n_clients-1:0]             cli_rsp_valid,
  output logic                             cli_rsp_err,
  output logic [8*word_bytes-1:0]          cli_rsp_data,
  output sys::mem_read_req_t               mem_req,
  input  sys::mem_read_rsp_t               mem_rsp
);

  localparam int unsigned ptr_w  = $clog2(n_clients);
  localparam int unsigned data_w = 8 * word_bytes;
  localparam logic [addr_width:0] mem_lim = (addr_width + 1)'(mem_size);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] ERROR   = 2'd3;

  logic [1:0]            state;
  logic [ptr_w-1:0]      rr_ptr;
  logic [ptr_w-1:0]      lat_g;
  logic [addr_width-1:0] lat_addr;
  logic [3:0]            lat_size;

  logic                  gnt_found;
  logic [ptr_w-1:0]      gnt_idx;
  int unsigned           cand;
  logic [addr_width-1:0] sel_addr;
  logic [3:0]            sel_size;
  logic [addr_width:0]   end_addr;
  logic                  req_bad;
  logic [data_w-1:0]     rdata;
  logic                  unused_rsp_done;

  assign unused_rsp_done = mem_rsp.done;

  // Round-robin search starting at rr_ptr, plus request validation of the winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < n_clients; i++) begin
      cand = (32'(rr_ptr) + i) % n_clients;
      if (!gnt_found && cli_req_valid[ptr_w'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ptr_w'(cand);
      end
    end
    sel_addr = cli_req_addr[32'(gnt_idx)*addr_width +: addr_width];
    sel_size = cli_req_size[32'(gnt_idx)*4 +: 4];
    // One extra bit keeps addr+size from wrapping past the top of the address space.
    end_addr = {1'b0, sel_addr} + {{(addr_width-3){1'b0}}, sel_size};
    req_bad  = (sel_size == 4'd0) || (32'(sel_size) > word_bytes) || (end_addr > mem_lim);
  end

  // Accept strobe is only offered while idle, so mid-access requests wait.
  always_comb begin
    cli_req_ready = '0;
    if (state == IDLE && gnt_found) cli_req_ready[gnt_idx] = 1'b1;
  end

  // FSM, round-robin pointer and latched request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lat_g    <= '0;
      lat_addr <= '0;
      lat_size <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            lat_g    <= gnt_idx;
            lat_addr <= sel_addr;
            lat_size <= sel_size;
            rr_ptr   <= (32'(gnt_idx) == n_clients - 1) ? '0 : gnt_idx + 1'b1;
            state    <= req_bad ? ERROR : ISSUE;
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory request is driven only during ISSUE.
  always_comb begin
    mem_req = '0;
    if (state == ISSUE) begin
      mem_req.en   = 1'b1;
      mem_req.addr = 32'(lat_addr);
      mem_req.size = lat_size;
    end
  end

  // Response to the latched client; bytes beyond the requested size read as zero.
  always_comb begin
    rdata         = data_w'(mem_rsp.data);
    cli_rsp_valid = '0;
    cli_rsp_err   = 1'b0;
    cli_rsp_data  = '0;
    if (state == CAPTURE) begin
      cli_rsp_valid[lat_g] = 1'b1;
      for (int unsigned b = 0; b < word_bytes; b++) begin
        if (b < 32'(lat_size)) cli_rsp_data[8*b +: 8] = rdata[8*b +: 8];
      end
    end else if (state == ERROR) begin
      cli_rsp_valid[lat_g] = 1'b1;
      cli_rsp_err          = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter with a behavioural 1-cycle sys_mem.
module tb_mem_read_arbiter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         cli_req_valid = '0;
  logic [3:0]         cli_req_ready;
  logic [127:0]       cli_req_addr = '0;
  logic [15:0]        cli_req_size = '0;
  logic [3:0]         cli_rsp_valid;
  logic               cli_rsp_err;
  logic [31:0]        cli_rsp_data;
  sys::mem_read_req_t mem_req;
  sys::mem_read_rsp_t mem_rsp;

  mem_read_arbiter #(
    .n_clients (4),
    .addr_width(32),
    .word_bytes(4),
    .mem_size  (1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cli_req_valid(cli_req_valid),
    .cli_req_ready(cli_req_ready),
    .cli_req_addr (cli_req_addr),
    .cli_req_size (cli_req_size),
    .cli_rsp_valid(cli_rsp_valid),
    .cli_rsp_err  (cli_rsp_err),
    .cli_rsp_data (cli_rsp_data),
    .mem_req      (mem_req),
    .mem_rsp      (mem_rsp)
  );

  always #5 clk = ~clk;

  // sys_mem model: registered read of four bytes.
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      mem_rsp <= '0;
    end else begin
      mem_rsp.done <= mem_req.en;
      if (mem_req.en) begin
        mem_rsp.data <= {mem[(mem_req.addr + 3) & 32'h3FF], mem[(mem_req.addr + 2) & 32'h3FF],
                         mem[(mem_req.addr + 1) & 32'h3FF], mem[mem_req.addr & 32'h3FF]};
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          client;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [3:0] onehot(input int c);
    logic [3:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && cli_rsp_valid != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {60'b0, cli_rsp_valid}, 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_client", {60'b0, cli_rsp_valid}, {60'b0, onehot(e.client)});
        chk("rsp_err", {63'b0, cli_rsp_err}, {63'b0, e.err});
        chk("rsp_data", {32'b0, cli_rsp_data}, {32'b0, e.data});
      end
    end
  end

  // Wait (bounded) for any ready; returns the number of extra negedges waited.
  task automatic wait_ready(output int w);
    w = 0;
    @(negedge clk);
    while (cli_req_ready == 4'b0 && w < 20) begin
      w++;
      @(negedge clk);
    end
  endtask

  // Raise the clients in mask (plus any already valid); expect client c to win.
  task automatic req(input logic [3:0] mask, input int c, input logic [31:0] a, input logic [3:0] s,
                     input bit exp_err, input logic [31:0] exp_data, input int exp_wait);
    int w;
    exp_t e;
    @(posedge clk); #1;
    cli_req_addr[c*32 +: 32] = a;
    cli_req_size[c*4 +: 4]   = s;
    cli_req_valid            = cli_req_valid | mask;
    wait_ready(w);
    if (w >= 20) begin
      chk("ready_timeout", 64'(w), 64'h0);
      cli_req_valid[c] = 1'b0;
      return;
    end
    chk("ready_onehot", {60'b0, cli_req_ready}, {60'b0, onehot(c)});
    if (exp_wait >= 0) chk("grant_wait", 64'(w), 64'(exp_wait));
    e.client = c; e.err = exp_err; e.data = exp_data;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cli_req_valid[c] = 1'b0;
    @(negedge clk);
    chk("mem_en_t1", {63'b0, mem_req.en}, {63'b0, !exp_err});
    if (!exp_err) begin
      chk("mem_addr_t1", {32'b0, mem_req.addr}, {32'b0, a});
      chk("mem_size_t1", {60'b0, mem_req.size}, {60'b0, s});
      chk("rsp_idle_t1", {60'b0, cli_rsp_valid}, 64'h0);
    end else begin
      chk("err_rsp_t1", {60'b0, cli_rsp_valid}, {60'b0, onehot(c)});
    end
    @(negedge clk);
    chk("mem_en_t2", {63'b0, mem_req.en}, 64'h0);
    chk("rsp_t2", {60'b0, cli_rsp_valid}, exp_err ? 64'h0 : {60'b0, onehot(c)});
  endtask

  initial begin
    int w;
    int last_cyc;
    exp_t e;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'h11; mem[16'h11] = 8'h22; mem[16'h12] = 8'h33; mem[16'h13] = 8'h44;
    mem[16'h20] = 8'hAA; mem[16'h21] = 8'hBB; mem[16'h22] = 8'hCC; mem[16'h23] = 8'hDD;
    for (int i = 0; i < 16; i++) mem[16'h40 + i] = 8'(8'h50 + i);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {60'b0, cli_req_ready}, 64'h0);
    chk("reset_rsp_valid", {60'b0, cli_rsp_valid}, 64'h0);
    chk("reset_rsp_err", {63'b0, cli_rsp_err}, 64'h0);
    chk("reset_rsp_data", {32'b0, cli_rsp_data}, 64'h0);
    chk("reset_mem_req", 64'(mem_req), 64'h0);

    // Single client 0 read of 11 22 33 44.
    req(4'b0001, 0, 32'h10, 4'd4, 1'b0, 32'h44332211, 0);

    // All four clients valid from reset: grants 0,1,2,3,0 at 3-cycle spacing.
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cli_req_addr[k*32 +: 32] = 32'h40 + 32'(4*k);
      cli_req_size[k*4 +: 4]   = 4'd4;
    end
    cli_req_valid = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ready(w);
      if (w >= 20) begin
        chk("rr_ready_timeout", 64'(w), 64'h0);
        break;
      end
      chk("rr_grant", {60'b0, cli_req_ready}, {60'b0, onehot(k % 4)});
      if (k > 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'd3);
      last_cyc = cyc;
      e.client = k % 4; e.err = 1'b0;
      case (k % 4)
        0: e.data = 32'h53525150;
        1: e.data = 32'h57565554;
        2: e.data = 32'h5B5A5958;
        default: e.data = 32'h5F5E5D5C;
      endcase
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (k == 4) cli_req_valid = '0;
    end
    repeat (3) @(negedge clk);

    // Out-of-range: 1022+4 > 1024.
    req(4'b0010, 1, 32'd1022, 4'd4, 1'b1, 32'h0, -1);
    // Partial-width read: upper bytes forced to zero.
    req(4'b1000, 3, 32'h20, 4'd2, 1'b0, 32'h0000BBAA, -1);
    // Client 2 twice; second has size 0 and is granted immediately.
    req(4'b0100, 2, 32'h10, 4'd4, 1'b0, 32'h44332211, 0);
    req(4'b0100, 2, 32'h20, 4'd0, 1'b1, 32'h0, 0);
    // rr_ptr now 3: with clients 0 and 3 valid, client 3 wins first.
    cli_req_addr[0 +: 32] = 32'h10;
    cli_req_size[0 +: 4]  = 4'd4;
    req(4'b1001, 3, 32'h20, 4'd3, 1'b0, 32'h00CCBBAA, 0);
    req(4'b0001, 0, 32'h10, 4'd4, 1'b0, 32'h44332211, 0);

    // Reset during ISSUE drops the access and returns rr_ptr to 0.
    @(posedge clk); #1;
    cli_req_addr[32 +: 32] = 32'h10;
    cli_req_size[4 +: 4]   = 4'd4;
    cli_req_valid[1]       = 1'b1;
    wait_ready(w);
    chk("rst_case_ready", {60'b0, cli_req_ready}, {60'b0, onehot(1)});
    @(posedge clk); #1;
    cli_req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_case_issue", {63'b0, mem_req.en}, 64'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_case_no_rsp", {60'b0, cli_rsp_valid}, 64'h0);
    chk("rst_case_mem_idle", {63'b0, mem_req.en}, 64'h0);
    @(negedge clk);
    chk("rst_case_no_rsp2", {60'b0, cli_rsp_valid}, 64'h0);
    cli_req_addr[96 +: 32] = 32'h40;
    cli_req_size[12 +: 4]  = 4'd1;
    req(4'b1001, 0, 32'h44, 4'd4, 1'b0, 32'h57565554, 0);
    req(4'b1000, 3, 32'h40, 4'd1, 1'b0, 32'h00000050, 0);

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
